// File: rtl/exec_writeback.sv
// Execute/write-back stage for the single-cycle core: latches one decoded
// RV32I OP-IMM instruction per step pulse, reads the register file, computes
// the ALU result, writes it back to rd, and counts retired instructions.
// Sequence per instruction: IDLE --step--> EXEC --> WB --> IDLE.
module exec_writeback #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,         // asynchronous, active-low
    input  logic                     step,
    input  logic [11:0]              imm,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [2:0]               alu_opcode,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [XLEN-1:0]          dbg_data,
    output logic [XLEN-1:0]          result,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              instret
);

    localparam int IDXW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADDI  = 3'b000;
    localparam logic [2:0] OP_SLLI  = 3'b001;
    localparam logic [2:0] OP_SLTI  = 3'b010;
    localparam logic [2:0] OP_SLTIU = 3'b011;
    localparam logic [2:0] OP_XORI  = 3'b100;
    localparam logic [2:0] OP_SRXI  = 3'b101;
    localparam logic [2:0] OP_ORI   = 3'b110;
    localparam logic [2:0] OP_ANDI  = 3'b111;

    state_e            state_q, state_d;
    logic [11:0]       imm_q;
    logic [IDXW-1:0]   rs1_q;
    logic [2:0]        op_q;
    logic [IDXW-1:0]   rd_q;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;
    logic [31:0]       instret_q, instret_d;
    logic              latch_en;
    logic              wr_en;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_sx;
    logic [4:0]        op_sh;
    logic [XLEN-1:0]   alu_res;

    // Operand A from the latched rs1 (x0 always reads zero), plus the
    // sign-extended immediate and the shift amount taken from imm[4:0].
    assign op_a  = (rs1_q == '0) ? '0 : regs_q[rs1_q];
    assign op_sx = {{(XLEN-12){imm_q[11]}}, imm_q};
    assign op_sh = imm_q[4:0];

    // ALU for the OP-IMM group, decoded from the latched funct3.
    // NOTE: every signal written in an always_comb gets a value before the
    // case statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADDI:  alu_res = op_a + op_sx;
            OP_SLTI:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_sx))};
            OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_sx)};
            OP_XORI:  alu_res = op_a ^ op_sx;
            OP_ORI:   alu_res = op_a | op_sx;
            OP_ANDI:  alu_res = op_a & op_sx;
            OP_SLLI:  alu_res = op_a << op_sh;
            OP_SRXI:  alu_res = imm_q[10] ? XLEN'($signed(op_a) >>> op_sh)
                                          : (op_a >> op_sh);
            default:  alu_res = '0;
        endcase
    end

    // Next-state and datapath control for the IDLE/EXEC/WB sequence.
    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        result_d  = result_q;
        done_d    = 1'b0;
        instret_d = instret_q;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step) begin
                    latch_en = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                state_d  = S_WB;
            end
            S_WB: begin
                wr_en     = (rd_q != '0);
                done_d    = 1'b1;
                instret_d = instret_q + 32'd1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, result, done pulse and retire counter; reset aborts any
    // in-flight instruction before it can reach the write-back edge.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            done_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            done_q    <= done_d;
            instret_q <= instret_d;
        end
    end

    // Capture the decoder fields on issue; the decoder may move on while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imm_q <= '0;
            rs1_q <= '0;
            op_q  <= '0;
            rd_q  <= '0;
        end else if (latch_en) begin
            imm_q <= imm;
            rs1_q <= rs1;
            op_q  <= alu_opcode;
            rd_q  <= rd;
        end
    end

    // Register file write port; x0 is never written and stays zero.
    // NOTE: the register file is built from flops and is cleared on reset,
    // so it is deliberately not a RAM-inferable array without reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_q] <= result_q;
        end
    end

    assign dbg_data = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
    assign result   = result_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Directed bench for exec_writeback: expected ALU results are pushed to a
// scoreboard at issue and compared when done pulses; register contents and
// the retire counter are checked through the debug port against constants.
module tb_exec_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  alu_opcode;
    logic [4:0]  rd;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [31:0] instret;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb_q [$];
    logic [31:0] m_rf [32];
    logic [31:0] m_instret;

    exec_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .imm        (imm),
        .rs1        (rs1),
        .alu_opcode (alu_opcode),
        .rd         (rd),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference OP-IMM behaviour written from the RV32I definitions.
    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [11:0] i,
                                              input logic [31:0] a);
        logic [31:0] sx;
        logic [4:0]  sh;
        sx = {{20{i[11]}}, i};
        sh = i[4:0];
        case (op)
            3'b000:  return a + sx;
            3'b010:  return ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
            3'b011:  return (a < sx) ? 32'd1 : 32'd0;
            3'b100:  return a ^ sx;
            3'b110:  return a | sx;
            3'b111:  return a & sx;
            3'b001:  return a << sh;
            default: return i[10] ? 32'($signed(a) >>> sh) : (a >> sh);
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest issued result.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            logic [31:0] exp_v;
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_v = sb_q.pop_front();
                check("sb_result", result, exp_v);
            end
        end
    end

    // Issue one instruction and follow it until done; the debug port watches
    // rd and must hold the old value until the write edge, then the new one.
    task automatic exec_instr(input string tag, input logic [11:0] i, input logic [4:0] s,
                              input logic [2:0] op, input logic [4:0] d);
        logic [31:0] exp_v;
        logic [31:0] old_v;
        bit          seen;
        exp_v = model_alu(op, i, (s == 5'd0) ? 32'd0 : m_rf[s]);
        old_v = (d == 5'd0) ? 32'd0 : m_rf[d];
        sb_q.push_back(exp_v);
        imm = i; rs1 = s; alu_opcode = op; rd = d; dbg_sel = d; step = 1'b1;
        @(negedge clk);
        step       = 1'b0;
        imm        = 12'($urandom);
        rs1        = 5'($urandom);
        alu_opcode = 3'($urandom);
        rd         = 5'($urandom);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_dbg_new"}, dbg_data, (d == 5'd0) ? 32'd0 : exp_v);
            end else begin
                check({tag, "_dbg_old"}, dbg_data, old_v);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (d != 5'd0) m_rf[d] = exp_v;
        m_instret++;
    endtask

    task automatic peek(input string tag, input logic [4:0] sel, input logic [31:0] exp_v);
        dbg_sel = sel;
        #1;
        check(tag, dbg_data, exp_v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [31:0] v;
        bit          seen;

        for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
        m_instret  = 32'd0;
        rst        = 1'b0;
        step       = 1'b0;
        imm        = '0;
        rs1        = '0;
        alu_opcode = '0;
        rd         = '0;
        dbg_sel    = 5'd5;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dbg_x5", dbg_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset during EXEC aborts ADDI x1,x0,5 without a write
        imm = 12'd5; rs1 = 5'd0; alu_opcode = 3'b000; rd = 5'd1; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("abort_busy_exec", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_instret", instret, 32'd0);
        check("abort_result", result, 32'd0);
        peek("abort_x1", 5'd1, 32'd0);
        @(negedge clk);

        // ADDI chain with read-after-write
        exec_instr("addi_x1", 12'd5, 5'd0, 3'b000, 5'd1);
        exec_instr("addi_x2", 12'hFFD, 5'd1, 3'b000, 5'd2);
        check("chain_result", result, 32'd2);
        check("chain_instret", instret, 32'd2);
        peek("chain_x1", 5'd1, 32'd5);
        peek("chain_x2", 5'd2, 32'd2);

        // Writes to x0 are discarded but still retire
        exec_instr("addi_x0", 12'd7, 5'd0, 3'b000, 5'd0);
        check("x0_result", result, 32'd7);
        check("x0_instret", instret, 32'd3);
        peek("x0_read", 5'd0, 32'd0);

        // Signed vs unsigned compare with x1 = 0xFFFFFFFF
        exec_instr("addi_m1", 12'hFFF, 5'd0, 3'b000, 5'd1);
        exec_instr("slti_x3", 12'h000, 5'd1, 3'b010, 5'd3);
        exec_instr("sltiu_x4", 12'h000, 5'd1, 3'b011, 5'd4);
        exec_instr("sltiu_x5", 12'hFFF, 5'd0, 3'b011, 5'd5);
        peek("cmp_x1", 5'd1, 32'hFFFF_FFFF);
        peek("cmp_x3", 5'd3, 32'd1);
        peek("cmp_x4", 5'd4, 32'd0);
        peek("cmp_x5", 5'd5, 32'd1);

        // Shifts and logic ops with x1 = 0xFFFFFFF0
        exec_instr("addi_m16", 12'hFF0, 5'd0, 3'b000, 5'd1);
        exec_instr("srai_x6", 12'h404, 5'd1, 3'b101, 5'd6);
        exec_instr("srli_x7", 12'h004, 5'd1, 3'b101, 5'd7);
        exec_instr("slli_x8", 12'h01F, 5'd1, 3'b001, 5'd8);
        exec_instr("xori_x10", 12'h0FF, 5'd1, 3'b100, 5'd10);
        exec_instr("ori_x11", 12'h800, 5'd0, 3'b110, 5'd11);
        exec_instr("andi_x12", 12'h7FF, 5'd1, 3'b111, 5'd12);
        exec_instr("slli_x13", 12'hFE4, 5'd1, 3'b001, 5'd13);
        exec_instr("srli_x14", 12'h3E4, 5'd1, 3'b101, 5'd14);
        peek("sh_x6", 5'd6, 32'hFFFF_FFFF);
        peek("sh_x7", 5'd7, 32'h0FFF_FFFF);
        peek("sh_x8", 5'd8, 32'h0000_0000);
        peek("lg_x10", 5'd10, 32'hFFFF_FF0F);
        peek("lg_x11", 5'd11, 32'hFFFF_F800);
        peek("lg_x12", 5'd12, 32'h0000_07F0);
        peek("sh_x13", 5'd13, 32'hFFFF_FF00);
        peek("sh_x14", 5'd14, 32'h0FFF_FFFF);
        check("mid_instret", instret, m_instret);

        // step held for 10 edges: accepted at 0, 3, 6, 9; busy steps ignored
        @(negedge clk);
        base = instret;
        imm = 12'd1; rs1 = 5'd9; alu_opcode = 3'b000; rd = 5'd9; dbg_sel = 5'd9; step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0) begin
                v = m_rf[9] + 32'd1;
                m_rf[9] = v;
                sb_q.push_back(v);
                m_instret++;
            end
            @(negedge clk);
        end
        step = 1'b0;
        check("hold_retired3", instret, base + 32'd3);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_x9_mid", dbg_data, 32'd3);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("hold_done_seen", 32'(seen), 32'd1);
        check("hold_instret", instret, base + 32'd4);
        peek("hold_x9", 5'd9, 32'd4);

        // Nothing further may retire once the queue is drained
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("final_instret", instret, m_instret);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
